cla_pipe_addsub: RTL

//  Parametrised pipelined adder/subtractor for wide datapath (squarer/accumulator paths).

---
 rtl/cla_pipe_pkg.sv | 30 +++
 rtl/cla_seg.sv | 32 +++
 rtl/cla_pipe_addsub.sv | 112 +++++++++++
 3 files changed

// File: rtl/cla_pipe_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder/subtractor: segment geometry
// and the per-stage control record.
package cla_pipe_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stage_ctl_t;

  function automatic int unsigned seg_w(int unsigned width, int unsigned stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int unsigned seg_lo(int unsigned k, int unsigned width,
                                         int unsigned stages);
    return k * seg_w(width, stages);
  endfunction

  // Trailing segments can be empty when ceil() rounding uses up WIDTH early.
  function automatic int unsigned seg_len(int unsigned k, int unsigned width,
                                          int unsigned stages);
    int unsigned lo;
    lo = seg_lo(k, width, stages);
    if (lo >= width) return 0;
    if (width - lo < seg_w(width, stages)) return width - lo;
    return seg_w(width, stages);
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational W-bit generate/propagate adder segment; also reports the carry into its
// top bit so the stage holding the operand MSB can derive signed overflow.
module cla_seg #(
  parameter int unsigned W = 13
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined adder/subtractor: one operand segment resolved per stage, carry and the
// unconsumed upper operand bits skewed forward, single global stall from the output side.
module cla_pipe_addsub
  import cla_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 49,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  // acc holds resolved sum bits below the current segment and raw A bits above it.
  stage_ctl_t       ctl_q [STAGES];
  stage_ctl_t       ctl_d [STAGES];
  logic [WIDTH-1:0] acc_q [STAGES];
  logic [WIDTH-1:0] acc_d [STAGES];
  logic [WIDTH-1:0] bop_q [STAGES];
  logic [WIDTH-1:0] bop_d [STAGES];
  logic             adv;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned Lo  = seg_lo(k, WIDTH, STAGES);
    localparam int unsigned Len = seg_len(k, WIDTH, STAGES);

    logic [WIDTH-1:0] acc_i;
    logic [WIDTH-1:0] bop_i;
    logic [WIDTH-1:0] acc_n;
    logic             vld_i;
    logic             cy_i;

    if (k == 0) begin : g_head
      // Subtraction resolves to A + ~B + 1 here, so later stages are mode-agnostic.
      assign acc_i = in_a;
      assign bop_i = in_sub ? ~in_b : in_b;
      assign vld_i = in_valid;
      assign cy_i  = in_sub | in_cin;
    end else begin : g_tail
      assign acc_i = acc_q[k-1];
      assign bop_i = bop_q[k-1];
      assign vld_i = ctl_q[k-1].valid;
      assign cy_i  = ctl_q[k-1].carry;
    end

    if (Len > 0) begin : g_add
      logic [Len-1:0] sum;
      logic           cout;
      logic           cmsb;

      cla_seg #(
        .W(Len)
      ) u_seg (
        .a   (acc_i[Lo +: Len]),
        .b   (bop_i[Lo +: Len]),
        .cin (cy_i),
        .sum (sum),
        .cout(cout),
        .cmsb(cmsb)
      );

      always_comb begin
        acc_n              = acc_i;
        acc_n[Lo +: Len]   = sum;
      end

      // Only the last non-empty segment holds the MSB; its ovf is the one that survives.
      assign ctl_d[k] = '{valid: vld_i, carry: cout, ovf: cmsb ^ cout};
    end else begin : g_pass
      assign acc_n    = acc_i;
      assign ctl_d[k] = '{valid: vld_i, carry: cy_i, ovf: ctl_q[k-1].ovf};
    end

    assign acc_d[k] = acc_n;
    assign bop_d[k] = bop_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        ctl_q[k] <= '0;
        acc_q[k] <= '0;
        bop_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        ctl_q[k] <= ctl_d[k];
        acc_q[k] <= acc_d[k];
        bop_q[k] <= bop_d[k];
      end
    end
  end

  assign out_valid = ctl_q[STAGES-1].valid;
  assign out_sum   = acc_q[STAGES-1];
  assign out_cout  = ctl_q[STAGES-1].carry;
  assign out_ovf   = ctl_q[STAGES-1].ovf;

endmodule
